// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main-control FSM and its datapath.
// The controller drives through the master modport and the datapath connects through the slave modport.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       adr_src;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op,
        output adr_src, ir_write, alu_src_a, alu_src_b, alu_op, result_src,
        output pc_update, branch, reg_write, mem_write, illegal_op, state
    );

    modport slave (
        output op,
        input  adr_src, ir_write, alu_src_a, alu_src_b, alu_op, result_src,
        input  pc_update, branch, reg_write, mem_write, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main-control FSM for a multicycle RISC-V datapath: it steps each instruction through
// fetch, decode, execute, memory and writeback, and drives the mux selects and write enables.
module multicycle_ctrl (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t r_state;
    state_t w_next_state;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    assign bus.state = r_state;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        w_next_state   = S_FETCH;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.result_src = 2'b00;
        bus.pc_update  = 1'b0;
        bus.branch     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                bus.ir_write   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.pc_update  = 1'b1;
                w_next_state   = S_DECODE;
            end
            S_DECODE: begin
                // The ALU precomputes OldPC + imm here so the BEQ state can use it as the target.
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      bus.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                w_next_state  = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.adr_src  = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
                w_next_state  = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
                w_next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.branch    = 1'b1;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_update = 1'b1;
                w_next_state  = S_ALUWB;
            end
            default: begin
                // Encodings 11-15 drive all outputs to zero and fall back to FETCH.
                w_next_state = S_FETCH;
            end
        endcase
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore main-control FSM for the multicycle RISC-V datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared ALU's operand muxes and the 2-bit ALUOp consumed by the ALU decoder (00 add, 01 sub, 10 funct-decoded).
- Drives register-file, memory, IR and PC write enables.

Parameters:
None. State encodings are fixed localparams.

Ports:
clk          in   1  system clock, rising-edge
reset        in   1  asynchronous, active-high reset
op           in   7  instr[6:0] from instruction register
adr_src      out  1  memory address mux: 0 PC, 1 ALU result
ir_write     out  1  IR/OldPC load enable
alu_src_a    out  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b    out  2  00 rs2 data, 01 ImmExt, 10 constant 4
alu_op       out  2  to ALU decoder: 00 add, 01 sub, 10 funct
result_src   out  2  00 ALUOut, 01 memory data, 10 ALU result
pc_update    out  1  unconditional PC write
branch       out  1  PC write qualified by Zero (external AND/OR)
reg_write    out  1  register-file write enable
mem_write    out  1  data-memory write enable
illegal_op   out  1  high in DECODE when op is unrecognised
state        out  4  current state encoding (debug/verification)

Behaviour:
- Reset: asynchronous, active-high. On assertion, state goes immediately to FETCH (0), independent of clk. It stays there while reset is high. The first transition occurs on the first rising clk edge after deassertion.
- Reset mid-instruction abandons the instruction. No further reg_write or mem_write is issued for it.
- Outputs are purely combinational from state (Moore), except illegal_op, which also depends on op.
- Any field not listed for a state is 0.
- Reset output values are the FETCH values.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
  - 6 EXECUTER, 7 EXECUTEI, 8 ALUWB, 9 BEQ, 10 JAL
  - 11-15 unused; any unused state returns to FETCH on the next edge with all outputs 0.
- Per-state outputs:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute).
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
- Transitions:
  - FETCH -> DECODE (always).
  - DECODE, decided by op:
    - 0000011 (lw) -> MEMADR
    - 0100011 (sw) -> MEMADR
    - 0110011 (R-type) -> EXECUTER
    - 0010011 (I-type ALU) -> EXECUTEI
    - 1100011 (beq) -> BEQ
    - 1101111 (jal) -> JAL
    - any other op -> FETCH, with illegal_op=1 during that DECODE cycle.
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB; JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Instruction latency in cycles, including FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- op is sampled only in DECODE and MEMADR. op changes in other states must not affect sequencing.
- Invariants: at most one of reg_write or mem_write is high in any state; pc_update and branch are never both high.

Test Plan:
- Reset held 3 cycles mid-EXECUTER (state=6), then released -> state=0 asynchronously with ir_write=1, pc_update=1, alu_src_b=10; next edge gives state=1.
- op=0000011 from reset release -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; adr_src=1 in state 3.
- op=0100011 -> state sequence 0,1,2,5,0; mem_write=1 for exactly one cycle (state 5); reg_write never high.
- op=0110011 then op=0010011 back-to-back -> sequences 0,1,6,8 then 0,1,7,8; alu_op=10 in states 6/7; alu_src_b=00 in 6 and 01 in 7.
- op=1100011 -> states 0,1,9,0; in state 9 alu_op=01 and branch=1. op=1101111 -> states 0,1,10,8,0; pc_update=1 in states 0 and 10.
- op=1111111 -> states 0,1,0; illegal_op=1 only in the DECODE cycle; no reg_write or mem_write pulse.
